// File: rtl/seq_multiplier_4x4_if.sv
// Start/done handshake bundle for the 4x4 sequential multiplier.
//   start   : request from the controller, sampled only while the multiplier is idle
//   a, b    : unsigned 4-bit operands, captured on the accepting edge
//   busy    : high while the multiplier iterates
//   done    : one-cycle pulse, product is valid
//   product : registered 8-bit result a*b
// master = surrounding control logic, slave = multiplier.
interface seq_multiplier_4x4_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier_4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// Each CALC cycle drives a 4-bit adder (A=acc, B=mcand gated by q[0], Cin=0)
// and shifts {Cout,Sum,q} right by one. Four iterations build the 8-bit product.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset; aborts any operation without a done
//   bus : handshake bundle (slave side): start, a, b in; busy, done, product out
// Timing: start accepted in cycle 0, busy in cycles 1-4, done in cycle 5,
// idle again (and able to accept) in cycle 6.
module seq_multiplier_4x4 (
    input  logic                       clk,
    input  logic                       rst,
    seq_multiplier_4x4_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] acc_q,   acc_d;
    logic [3:0] q_q,     q_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [7:0] product_q, product_d;

    // Adder hookup (stands in for the 4-bit ripple-carry adder instance).
    logic [3:0] adder_a;
    logic [3:0] adder_b;
    logic       adder_cin;
    logic [3:0] adder_sum;
    logic       adder_cout;

    always_comb begin
        adder_a   = acc_q;
        adder_b   = q_q[0] ? mcand_q : 4'b0000;
        adder_cin = 1'b0;
        {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0000, adder_cin};
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    q_d     = bus.b;
                    acc_d   = 4'b0000;
                    cnt_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // The carry is kept by shifting Cout into acc[3], so a sum
                // that overflows 4 bits never loses its top bit.
                acc_d = {adder_cout, adder_sum[3:1]};
                q_d   = {adder_sum[0], q_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = {acc_d, q_d};
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 4'b0000;
            acc_q     <= 4'b0000;
            q_q       <= 4'b0000;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Decoded straight from the state register: no path from inputs.
    assign bus.busy    = (state_q == CALC);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier_4x4.sv
// Self-checking bench for seq_multiplier_4x4: table-driven vectors, hand
// sequences for held start and mid-operation reset, and an exhaustive sweep.
// Expected products are queued when a start is accepted and popped at done.
module tb_seq_multiplier_4x4;

    logic clk;
    logic rst;

    seq_multiplier_4x4_if bus ();

    seq_multiplier_4x4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        string      name;
    } vec_t;

    int         total;
    int         bad;
    int         done_seen;
    logic [7:0] last_prod;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and sample 1 ns after the edge; any done pulse is
    // matched against the scoreboard.
    task automatic step();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'b0, bus.done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("product_at_done", {24'b0, bus.product}, {24'b0, e});
                last_prod = e;
            end
        end
    endtask

    // Called in an idle cycle ("cycle 0"); returns in cycle 6, idle again.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp, input string name);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        step();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        for (int c = 1; c <= 4; c++) begin
            check({name, "_busy_calc"}, {31'b0, bus.busy}, 32'd1);
            check({name, "_nodone_calc"}, {31'b0, bus.done}, 32'd0);
            check({name, "_prod_hold_calc"}, {24'b0, bus.product}, {24'b0, last_prod});
            step();
        end
        check({name, "_done_c5"}, {31'b0, bus.done}, 32'd1);
        check({name, "_busy_c5"}, {31'b0, bus.busy}, 32'd0);
        step();
        check({name, "_done_c6"}, {31'b0, bus.done}, 32'd0);
        check({name, "_busy_c6"}, {31'b0, bus.busy}, 32'd0);
        check({name, "_prod_c6"}, {24'b0, bus.product}, {24'b0, exp});
    endtask

    vec_t vecs[4];
    int   done_before;

    initial begin
        total     = 0;
        bad       = 0;
        done_seen = 0;
        last_prod = 8'h00;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 8'h0F, name: "v3x5"};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'hE1, name: "v15x15"};
        vecs[2] = '{a: 4'd9,  b: 4'd0,  exp: 8'h00, name: "v9x0"};
        vecs[3] = '{a: 4'd0,  b: 4'd9,  exp: 8'h00, name: "v0x9"};

        // Reset state
        step();
        step();
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_product", {24'b0, bus.product}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", {31'b0, bus.busy}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        // start held high: ignored in CALC/DONE, next accept in cycle 6
        bus.a     = 4'd6;
        bus.b     = 4'd7;
        bus.start = 1'b1;
        exp_q.push_back(8'h2A);
        step();
        for (int c = 1; c <= 4; c++) begin
            check("held_busy_first", {31'b0, bus.busy}, 32'd1);
            step();
        end
        check("held_done_c5", {31'b0, bus.done}, 32'd1);
        check("held_prod_c5", {24'b0, bus.product}, 32'h2A);
        bus.a = 4'd2;
        bus.b = 4'd3;
        step();
        check("held_busy_c6", {31'b0, bus.busy}, 32'd0);
        check("held_done_c6", {31'b0, bus.done}, 32'd0);
        exp_q.push_back(8'h06);
        step();
        for (int c = 7; c <= 10; c++) begin
            check("held_busy_second", {31'b0, bus.busy}, 32'd1);
            check("held_prod_hold", {24'b0, bus.product}, 32'h2A);
            step();
        end
        check("held_done_c11", {31'b0, bus.done}, 32'd1);
        check("held_prod_c11", {24'b0, bus.product}, 32'h06);
        bus.start = 1'b0;
        step();
        check("held_idle_c12", {31'b0, bus.busy}, 32'd0);

        // Reset in cycle 2 of an operation aborts it with no done
        bus.a     = 4'd5;
        bus.b     = 4'd5;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_product", {24'b0, bus.product}, 32'd0);
        rst       = 1'b0;
        last_prod = 8'h00;
        done_before = done_seen;
        for (int c = 0; c < 6; c++) begin
            step();
        end
        check("abort_no_done", done_seen - done_before, 32'd0);
        run_op(4'd2, 4'd4, 8'h08, "after_abort");

        // Exhaustive, back-to-back at the 6-cycle cadence
        done_before = done_seen;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 8'(i * j), "sweep");
            end
        end
        check("sweep_done_count", done_seen - done_before, 32'd256);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
